btn_event_unit: RTL and testbench
=================================

Name: btn_event_unit

Overview:
Button front-end that produces the 4-bit button word read by nnRvSoc, in the order {BTND, BTNU, BTNR, BTNL}.
- Synchronises each raw board button to CLK and debounces it.
- Presents a stable level per button.
- Latches sticky press and release events, which software clears with a per-bit write strobe.
- Raises a level interrupt while any press event is pending.
- Sits between the board pins and the SoC peripheral read/write decode.

Parameters:
NUM_BTN, 4, number of buttons; bit 0=BTNL, 1=BTNR, 2=BTNU, 3=BTND.
DEBOUNCE_CYCLES, 125000, consecutive CLK cycles a synchronised input must differ from the stable level before the level flips (10 ms at 12.5 MHz); legal range >= 2.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width.

Ports:
CLK  input  1  system clock, the same CLK that drives nnRvSoc.
RST_N  input  1  reset: asynchronous assert, active-low.
btn_raw  input  NUM_BTN  raw pad levels, active-high, asynchronous to CLK.
btn_level  output  NUM_BTN  debounced stable level.
btn_press  output  NUM_BTN  sticky flag per button: a 0->1 transition of btn_level has occurred.
btn_release  output  NUM_BTN  sticky flag per button: a 1->0 transition of btn_level has occurred.
clr_strobe  input  1  one-cycle write strobe from the SoC.
clr_mask  input  2*NUM_BTN  bits [NUM_BTN-1:0] clear btn_press; bits [2*NUM_BTN-1:NUM_BTN] clear btn_release; sampled only when clr_strobe=1.
irq  output  1  high while any btn_press bit is set; registered.

Behaviour:
- Reset (RST_N=0, asynchronous): sync flops, counters, btn_level, btn_press, btn_release and irq all go to 0. Release is synchronous to the next CLK rising edge.
- Synchroniser: 2-flop chain per bit, giving sync[i]. Raw-to-sync latency is 2 edges. No combinational path from btn_raw to any output.
- Debounce, per bit, on each rising edge:
  - sync == btn_level: cnt <= 0.
  - sync != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= sync, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any glitch back to the stable value before the count completes resets cnt. No partial credit is kept.
  - A clean raw step reaches btn_level exactly DEBOUNCE_CYCLES+2 edges after the first edge at which it is sampled.
- Event latch, on the same edge that btn_level flips:
  - 0->1 sets btn_press[i].
  - 1->0 sets btn_release[i].
  - Flags hold until cleared or reset; multiple presses collapse into one set flag.
- Clear: when clr_strobe=1, each flag bit with its clr_mask bit = 1 clears at that edge. Mask bits are ignored when clr_strobe=0.
- Simultaneous set and clear on the same bit at the same edge: set wins, so the event is never lost.
- irq <= |(btn_press next-state). irq therefore changes on the same edge as the flags, with no extra cycle.
- Buttons are fully independent; simultaneous transitions on several bits are all latched.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Decomposition:
- Shared package btn_pkg:
  - NUM_BTN default.
  - Bit index constants BTN_L=0, BTN_R=1, BTN_U=2, BTN_D=3.
  - Clear-mask field offsets PRESS_OFS=0, RELEASE_OFS=NUM_BTN.
- Sub-module btn_debounce_cell, instantiated NUM_BTN times via generate.
  - Contains one button's synchroniser, counter and stable level.
  - Outputs the level plus one-cycle rise/fall pulses.
- Top level holds the sticky flags, the clear logic and irq.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
- Clean press: btn_raw=4'b0001 held -> btn_level[0]=1, btn_press=4'b0001 and irq=1, all at edge 6 after sampling; other bits stay 0.
- Bounce reject: btn_raw[2] toggles 1,0,1,0 with 3-cycle periods, then holds 1 -> no btn_level change during the bouncing; btn_level[2]=1 exactly 6 edges after the final rise; btn_press=4'b0100, set once.
- Release and clear: release BTNL after the press -> btn_release[0]=1. Then clr_strobe=1, clr_mask=8'h11 -> btn_press=0, btn_release=0, irq=0 on the next edge.
- Set/clear collision: clr_strobe=1 with clr_mask[3]=1 on the exact edge btn_level[3] rises -> btn_press[3] remains 1 and irq remains 1.
- Multi-button: btn_raw=4'b1111 in one cycle -> all four levels and btn_press=4'hF on the same edge. A clear with mask 8'h05 -> btn_press=4'hA, irq=1.
- Reset mid-count: assert RST_N=0 at cnt=2 with the button held, release reset -> all outputs 0 immediately; btn_level rises 6 edges after reset release, not earlier.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for the button front-end.
// Bit indices and clear-mask field offsets.
package btn_pkg;

  localparam int NUM_BTN = 4;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

  localparam int PRESS_OFS   = 0;
  localparam int RELEASE_OFS = NUM_BTN;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchroniser, debounce counter, stable level.
// Ports: CLK, RST_N, raw in; level, rise/fall one-cycle pulses out.
module btn_debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             done;

  // Pulses are high on the edge where level flips,
  // derived only from registered state.
  assign done = (sync != level) && (cnt == LAST);
  assign rise = done & sync;
  assign fall = done & ~sync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (done) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_event_unit.sv
// Button front-end: debounced levels, sticky press/release flags, irq.
// Ports: CLK, RST_N, btn_raw, clr_strobe, clr_mask in; btn_level, btn_press, btn_release, irq out.
module btn_event_unit #(
  parameter int NUM_BTN = btn_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_BTN-1:0]   btn_raw,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_press,
  output logic [NUM_BTN-1:0]   btn_release,
  input  logic                 clr_strobe,
  input  logic [2*NUM_BTN-1:0] clr_mask,
  output logic                 irq
);

  import btn_pkg::*;

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic [NUM_BTN-1:0] clr_p;
  logic [NUM_BTN-1:0] clr_r;
  logic [NUM_BTN-1:0] press_nxt;
  logic [NUM_BTN-1:0] rel_nxt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .CLK  (CLK),
      .RST_N(RST_N),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Set is OR-ed after the clear so a new event is never lost.
  always_comb begin
    clr_p     = '0;
    clr_r     = '0;
    if (clr_strobe) begin
      clr_p = clr_mask[PRESS_OFS +: NUM_BTN];
      clr_r = clr_mask[RELEASE_OFS +: NUM_BTN];
    end
    press_nxt = (btn_press & ~clr_p) | rise;
    rel_nxt   = (btn_release & ~clr_r) | fall;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_press   <= '0;
      btn_release <= '0;
      irq         <= 1'b0;
    end else begin
      btn_press   <= press_nxt;
      btn_release <= rel_nxt;
      irq         <= |press_nxt;
    end
  end

endmodule

// File: tb/tb_btn_event_unit.sv
// Bench for btn_event_unit with DEBOUNCE_CYCLES=4.
// Directed literal checks plus randomized run against a window model.
module tb_btn_event_unit;

  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       clr_strobe;
  logic [7:0] clr_mask;
  logic       irq;

  int checks = 0;
  int errors = 0;
  bit en = 0;

  btn_event_unit #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .clr_strobe (clr_strobe),
    .clr_mask   (clr_mask),
    .irq        (irq)
  );

  always #5 CLK = ~CLK;

  // Model: raw samples taken at the last D+1 edges. Level flips at
  // edge n when raw sampled at edges n-D-1..n-2 all oppose the level.
  logic [3:0] hist [0:D];
  logic [3:0] m_lvl;
  logic [3:0] m_press;
  logic [3:0] m_rel;
  logic       m_irq;
  logic [3:0] r_e;
  logic [3:0] f_e;
  logic [3:0] cp;
  logic [3:0] cr;
  logic [3:0] pn;
  bit         all_opp;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k <= D; k++) hist[k] <= '0;
      m_lvl   <= '0;
      m_press <= '0;
      m_rel   <= '0;
      m_irq   <= 1'b0;
    end else begin
      r_e = '0;
      f_e = '0;
      for (int b = 0; b < 4; b++) begin
        all_opp = 1;
        for (int k = 1; k <= D; k++)
          if (hist[k][b] == m_lvl[b]) all_opp = 0;
        if (all_opp) begin
          if (m_lvl[b]) f_e[b] = 1'b1;
          else r_e[b] = 1'b1;
        end
      end
      cp = clr_strobe ? clr_mask[3:0] : 4'h0;
      cr = clr_strobe ? clr_mask[7:4] : 4'h0;
      pn = (m_press & ~cp) | r_e;
      for (int k = 1; k <= D; k++) hist[k] <= hist[k-1];
      hist[0] <= btn_raw;
      m_lvl   <= m_lvl ^ (r_e | f_e);
      m_press <= pn;
      m_rel   <= (m_rel & ~cr) | f_e;
      m_irq   <= |pn;
    end
  end

  always @(negedge CLK) begin
    if (en) begin
      checks++;
      if ({btn_level, btn_press, btn_release, irq} !==
          {m_lvl, m_press, m_rel, m_irq}) begin
        errors++;
        $display("FAIL model t=%0t got lvl=%h prs=%h rel=%h irq=%b want lvl=%h prs=%h rel=%h irq=%b",
                 $time, btn_level, btn_press, btn_release, irq,
                 m_lvl, m_press, m_rel, m_irq);
      end
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(logic [3:0] r, logic s, logic [7:0] m);
    @(negedge CLK);
    #1;
    btn_raw    = r;
    clr_strobe = s;
    clr_mask   = m;
  endtask

  task automatic we(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N      = 1'b1;
    btn_raw    = '0;
    clr_strobe = 1'b0;
    clr_mask   = '0;
    #2 RST_N = 1'b0;
    we(2);
    chk("rst_lvl", {4'h0, btn_level}, 8'h00);
    chk("rst_flags", {btn_press, btn_release}, 8'h00);
    chk("rst_irq", {7'h0, irq}, 8'h00);
    @(negedge CLK);
    #1 RST_N = 1'b1;
    en = 1;

    // clean press
    drv(4'b0001, 0, 8'h00);
    we(5);
    chk("press_early", {4'h0, btn_level}, 8'h00);
    we(1);
    chk("press_lvl", {4'h0, btn_level}, 8'h01);
    chk("press_flag", {4'h0, btn_press}, 8'h01);
    chk("press_irq", {7'h0, irq}, 8'h01);

    // release and clear
    drv(4'b0000, 0, 8'h00);
    we(6);
    chk("rel_lvl", {4'h0, btn_level}, 8'h00);
    chk("rel_flag", {4'h0, btn_release}, 8'h01);
    drv(4'b0000, 1, 8'h11);
    we(1);
    chk("clr_flags", {btn_press, btn_release}, 8'h00);
    chk("clr_irq", {7'h0, irq}, 8'h00);

    // bounce reject on BTNU
    drv(4'b0100, 0, 8'h00);
    we(3);
    drv(4'b0000, 0, 8'h00);
    we(3);
    drv(4'b0100, 0, 8'h00);
    we(3);
    drv(4'b0000, 0, 8'h00);
    we(3);
    chk("bounce_hold", {4'h0, btn_level}, 8'h00);
    drv(4'b0100, 0, 8'h00);
    we(5);
    chk("bounce_early", {4'h0, btn_level}, 8'h00);
    we(1);
    chk("bounce_lvl", {4'h0, btn_level}, 8'h04);
    chk("bounce_prs", {4'h0, btn_press}, 8'h04);

    drv(4'b0000, 0, 8'h00);
    we(6);
    drv(4'b0000, 1, 8'hFF);
    we(1);
    drv(4'b0000, 0, 8'h00);

    // set/clear collision on BTND
    drv(4'b1000, 0, 8'h00);
    we(5);
    drv(4'b1000, 1, 8'h08);
    we(1);
    chk("coll_lvl", {4'h0, btn_level}, 8'h08);
    chk("coll_prs", {4'h0, btn_press}, 8'h08);
    chk("coll_irq", {7'h0, irq}, 8'h01);
    drv(4'b0000, 0, 8'h00);
    we(6);
    drv(4'b0000, 1, 8'hFF);
    we(1);

    // multi-button
    drv(4'b1111, 0, 8'h00);
    we(5);
    chk("multi_early", {4'h0, btn_level}, 8'h00);
    we(1);
    chk("multi_lvl", {4'h0, btn_level}, 8'h0F);
    chk("multi_prs", {4'h0, btn_press}, 8'h0F);
    drv(4'b1111, 1, 8'h05);
    we(1);
    chk("multi_clr", {4'h0, btn_press}, 8'h0A);
    chk("multi_irq", {7'h0, irq}, 8'h01);
    drv(4'b1111, 0, 8'h00);

    // reset mid-count
    drv(4'b0000, 0, 8'h00);
    RST_N = 1'b0;
    we(1);
    drv(4'b0000, 0, 8'h00);
    RST_N = 1'b1;
    drv(4'b0001, 0, 8'h00);
    we(4);
    drv(4'b0001, 0, 8'h00);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_lvl", {4'h0, btn_level}, 8'h00);
    chk("mid_rst_flg", {btn_press, btn_release}, 8'h00);
    we(2);
    drv(4'b0001, 0, 8'h00);
    RST_N = 1'b1;
    we(5);
    chk("mid_early", {4'h0, btn_level}, 8'h00);
    we(1);
    chk("mid_lvl", {4'h0, btn_level}, 8'h01);
    chk("mid_prs", {4'h0, btn_press}, 8'h01);

    // randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] r;
      logic       s;
      r = btn_raw;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      s = ($urandom_range(7) == 0);
      drv(r, s, 8'($urandom));
    end
    drv(4'b0000, 0, 8'h00);
    we(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
